// File: rtl/paged_ram.sv
// paged_ram: banked RAM on a tri-state bus with programmable wait states,
// per-bank write protection and a lockable page (bank) register.
module paged_ram #(
   parameter int                      DW          = 8,
   parameter int                      AW          = 14,
   parameter int                      BANK_BITS   = 3,
   parameter int                      WAIT_STATES = 1,
   parameter logic [2**BANK_BITS-1:0] WP_MASK     = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   input  logic                 oce,
   input  logic                 wre,
   input  logic [AW-1:0]        ad,
   inout  wire  [DW-1:0]        data_bus,
   input  logic                 page_we,
   input  logic [BANK_BITS:0]   page_din,
   output logic [BANK_BITS-1:0] bank,
   output logic                 ready,
   output logic                 wp_err
);
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [AW-1:0]        ad_q, ad_d;
   logic                 wre_q, wre_d;
   logic [DW-1:0]        wdat_q, wdat_d, dout_q, dout_d;
   logic [BANK_BITS-1:0] lbank_q, lbank_d, bank_q, bank_d;
   logic                 lock_q, lock_d, wp_err_q, wp_err_d;
   logic                 capture, do_acc, mem_we, drive;
   logic [DW-1:0]        mem [2**(AW+BANK_BITS)];

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   state_d = !ce ? S_IDLE : (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
         S_WAIT:   state_d = !ce ? S_IDLE : (cnt_q == 4'd1) ? S_ACCESS : S_WAIT;
         S_ACCESS: state_d = ce ? S_DONE : S_IDLE;
         default:  state_d = ce ? S_DONE : S_IDLE;
      endcase
   end

   always_comb begin
      ready = state_q == S_DONE;
      drive = state_q == S_DONE && ce && oce && !wre_q;
   end

   // The request uses the page register value from before any coincident page_we.
   always_comb begin
      capture  = state_q == S_IDLE && ce;
      do_acc   = state_q == S_ACCESS && ce;
      mem_we   = do_acc && wre_q && !WP_MASK[lbank_q];
      ad_d     = capture ? ad : ad_q;
      wre_d    = capture ? wre : wre_q;
      wdat_d   = capture ? data_bus : wdat_q;
      lbank_d  = capture ? bank_q : lbank_q;
      cnt_d    = capture ? WS : (state_q == S_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
      dout_d   = (do_acc && !wre_q) ? mem[{lbank_q, ad_q}] : dout_q;
      wp_err_d = do_acc && wre_q && WP_MASK[lbank_q];
      bank_d   = (page_we && !lock_q) ? page_din[BANK_BITS-1:0] : bank_q;
      lock_d   = (page_we && !lock_q) ? page_din[BANK_BITS] : lock_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         ad_q     <= '0;
         wre_q    <= 1'b0;
         wdat_q   <= '0;
         lbank_q  <= '0;
         dout_q   <= '0;
         wp_err_q <= 1'b0;
         bank_q   <= '0;
         lock_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         ad_q     <= ad_d;
         wre_q    <= wre_d;
         wdat_q   <= wdat_d;
         lbank_q  <= lbank_d;
         dout_q   <= dout_d;
         wp_err_q <= wp_err_d;
         bank_q   <= bank_d;
         lock_q   <= lock_d;
      end
   end

   // Contents survive reset; a reset edge only cancels the pending write.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) mem[{lbank_q, ad_q}] <= wdat_q;
   end

   assign data_bus = drive ? dout_q : 'z;
   assign bank     = bank_q;
   assign wp_err   = wp_err_q;
endmodule

// File: tb/tb_paged_ram.sv
// tb_paged_ram: three paged_ram configurations (WS=1, WS=0 with bank 0
// protected, WS=4) driven by directed and random accesses against a scoreboard.
module tb_paged_ram;
   localparam logic [11:0] WS_T = {4'd4, 4'd0, 4'd1};
   localparam logic [23:0] WP_T = {8'h00, 8'h01, 8'h00};

   typedef struct {
      int         k;
      bit         wr;
      bit         chk;
      logic [7:0] data;
      bit         wp;
      int         lat;
      int         t0;
      int         key;
      logic [2:0] bnk;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] ce, oce, wre, page_we, drv_en, ready, wp_err, rdy_p;
   logic [13:0] ad [3];
   logic [3:0]  page_din [3];
   logic [2:0]  bnk [3];
   logic [7:0]  drv_dat [3];
   logic [7:0]  bus_v [3];
   int          cyc = 0;
   int          compared = 0;
   int          fails = 0;
   exp_t        sbq [$];
   exp_t        cur [3];
   logic [7:0]  mm [int];
   logic [7:0]  learned [int];
   logic [2:0]  pbank [3];
   logic        plock [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      wire [7:0] dbus;
      assign dbus = drv_en[g] ? drv_dat[g] : 8'bz;
      assign bus_v[g] = dbus;
      paged_ram #(
         .DW(8), .AW(14), .BANK_BITS(3),
         .WAIT_STATES(int'(WS_T[g*4 +: 4])),
         .WP_MASK(WP_T[g*8 +: 8])
      ) u_dut (
         .clk(clk), .reset(reset), .ce(ce[g]), .oce(oce[g]), .wre(wre[g]),
         .ad(ad[g]), .data_bus(dbus), .page_we(page_we[g]), .page_din(page_din[g]),
         .bank(bnk[g]), .ready(ready[g]), .wp_err(wp_err[g])
      );
   end

   function automatic int ws_of(input int k);
      return int'(WS_T[k*4 +: 4]);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         pbank[k] = '0;
         plock[k] = 1'b0;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      ce = '0;
      page_we = '0;
      drv_en = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
   endtask

   task automatic setpage(input int k, input logic [3:0] din);
      @(posedge clk);
      #1 page_we[k] = 1'b1;
      page_din[k] = din;
      if (!plock[k]) begin
         pbank[k] = din[2:0];
         plock[k] = din[3];
      end
      @(posedge clk);
      #1 page_we[k] = 1'b0;
   endtask

   // pw: 0 = no page write, 1 = page write at capture, 2 = page write while in flight
   task automatic access(input int k, input bit wr, input logic [13:0] a, input logic [7:0] d,
                         input int pw, input logic [2:0] nb);
      exp_t e;
      int   n;
      @(posedge clk);
      #1 ce[k] = 1'b1;
      wre[k] = wr;
      ad[k] = a;
      oce[k] = 1'b1;
      drv_en[k] = wr;
      drv_dat[k] = d;
      e.k = k;
      e.wr = wr;
      e.t0 = cyc;
      e.lat = ws_of(k) + 2;
      e.key = (k << 17) | (int'(pbank[k]) << 14) | int'(a);
      e.wp = wr && WP_T[k*8 + int'(pbank[k])];
      e.data = d;
      e.chk = 1'b0;
      if (wr) begin
         if (!e.wp) mm[e.key] = d;
      end else if (mm.exists(e.key)) begin
         e.chk = 1'b1;
         e.data = mm[e.key];
      end else if (learned.exists(e.key)) begin
         e.chk = 1'b1;
         e.data = learned[e.key];
      end
      if (pw == 1) begin
         page_we[k] = 1'b1;
         page_din[k] = {1'b0, nb};
         pbank[k] = nb;
      end
      e.bnk = pbank[k];
      sbq.push_back(e);
      @(posedge clk);
      #1 page_we[k] = 1'b0;
      drv_en[k] = 1'b0;
      wre[k] = 1'($urandom);
      ad[k] = 14'($urandom);
      if (pw == 2) begin
         page_we[k] = 1'b1;
         page_din[k] = {1'b0, nb};
         pbank[k] = nb;
         sbq[sbq.size()-1].bnk = nb;
      end
      n = 0;
      while (!ready[k] && n < 20) begin
         @(posedge clk);
         #1 page_we[k] = 1'b0;
         n++;
      end
      if (n == 20) begin
         chk("ready_timeout", ready[k], 1'b1);
         if (sbq.size() > 0) void'(sbq.pop_back());
      end
      @(posedge clk);
      #1 oce[k] = 1'($urandom);
      @(posedge clk);
      #1 ce[k] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic abort_at(input int k, input logic [13:0] a, input logic [7:0] d, input int drop);
      @(posedge clk);
      #1 ce[k] = 1'b1;
      wre[k] = 1'b1;
      ad[k] = a;
      oce[k] = 1'b0;
      drv_en[k] = 1'b1;
      drv_dat[k] = d;
      repeat (drop) begin
         @(posedge clk);
         #1 drv_en[k] = 1'b0;
      end
      ce[k] = 1'b0;
      repeat (ws_of(k) + 3) begin
         @(posedge clk);
         #1 chk("abort_ready", ready[k], 1'b0);
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (ready[k] && !rdy_p[k]) begin
            if (sbq.size() == 0) chk("spurious_ready", ready[k], 1'b0);
            else begin
               cur[k] = sbq.pop_front();
               chk("dut_index", k, cur[k].k);
               chk("latency", cyc - cur[k].t0, cur[k].lat);
               chk("wp_err", wp_err[k], cur[k].wp);
               chk("bank", bnk[k], cur[k].bnk);
               if (!cur[k].wr && cur[k].chk) chk("rdata", bus_v[k], cur[k].data);
               else if (!cur[k].wr) learned[cur[k].key] = bus_v[k];
            end
         end else if (ready[k]) begin
            chk("wp_err_once", wp_err[k], 1'b0);
            if (ce[k] && oce[k] && !cur[k].wr && cur[k].chk) chk("rdata_hold", bus_v[k], cur[k].data);
         end else if (wp_err[k]) chk("wp_err_idle", wp_err[k], 1'b0);
         rdy_p[k] = ready[k];
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [13:0] apool [4];
      apool = '{14'h0000, 14'h0001, 14'h0010, 14'h3FFF};
      reset = 1'b1;
      ce = '0;
      oce = '0;
      wre = '0;
      page_we = '0;
      drv_en = '0;
      rdy_p = '0;
      for (int k = 0; k < 3; k++) begin
         ad[k] = '0;
         page_din[k] = '0;
         drv_dat[k] = '0;
      end
      do_reset();
      for (int k = 0; k < 3; k++) begin
         chk("rst_ready", ready[k], 1'b0);
         chk("rst_wp_err", wp_err[k], 1'b0);
         chk("rst_bank", bnk[k], 3'd0);
      end
      access(0, 1'b1, 14'h0010, 8'hA5, 0, 3'd0);
      access(0, 1'b0, 14'h0010, 8'h00, 0, 3'd0);
      setpage(0, 4'h2);
      access(0, 1'b1, 14'h0000, 8'h11, 0, 3'd0);
      setpage(0, 4'h5);
      access(0, 1'b1, 14'h0000, 8'h22, 0, 3'd0);
      setpage(0, 4'h2);
      access(0, 1'b0, 14'h0000, 8'h00, 0, 3'd0);
      setpage(0, 4'h5);
      access(0, 1'b0, 14'h0000, 8'h00, 0, 3'd0);
      setpage(1, 4'h0);
      access(1, 1'b0, 14'h0000, 8'h00, 0, 3'd0);
      access(1, 1'b1, 14'h0000, 8'h77, 0, 3'd0);
      access(1, 1'b0, 14'h0000, 8'h00, 0, 3'd0);
      setpage(1, 4'h1);
      access(1, 1'b1, 14'h0000, 8'h55, 0, 3'd0);
      access(1, 1'b0, 14'h0000, 8'h00, 0, 3'd0);
      setpage(0, 4'h0);
      abort_at(0, 14'h0010, 8'h3C, 1);
      access(0, 1'b0, 14'h0010, 8'h00, 0, 3'd0);
      access(2, 1'b1, 14'h0020, 8'h99, 0, 3'd0);
      abort_at(2, 14'h0020, 8'h66, 5);
      access(2, 1'b0, 14'h0020, 8'h00, 0, 3'd0);
      @(posedge clk);
      #1 ce[0] = 1'b1;
      wre[0] = 1'b1;
      ad[0] = 14'h0010;
      drv_en[0] = 1'b1;
      drv_dat[0] = 8'hEE;
      oce[0] = 1'b0;
      @(posedge clk);
      #1 drv_en[0] = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 chk("reset_in_access_ready", ready[0], 1'b0);
      chk("reset_in_access_bank", bnk[0], 3'd0);
      reset = 1'b0;
      ce[0] = 1'b0;
      model_reset();
      @(posedge clk);
      #1 chk("reset_in_access_idle", ready[0], 1'b0);
      access(0, 1'b0, 14'h0010, 8'h00, 0, 3'd0);
      setpage(0, 4'b1011);
      chk("lock_set_bank", bnk[0], 3'd3);
      setpage(0, 4'b0001);
      chk("lock_hold_bank", bnk[0], 3'd3);
      do_reset();
      chk("lock_reset_bank", bnk[0], 3'd0);
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 30; i++) begin
            access(k, 1'($urandom), apool[$urandom_range(0, 3)], 8'($urandom),
                   $urandom_range(0, 2), 3'($urandom));
         end
      end
      repeat (3) @(posedge clk);
      #1 chk("scoreboard_empty", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
      $finish;
   end
endmodule

// File: doc/paged_ram.md
PAGED_RAM -- requirements
Module: paged_ram

Interface
REQ-001 SHALL provide parameter DW, default 8, data bus width in bits.
REQ-002 SHALL provide parameter AW, default 14, in-page address width (16 KB page at DW=8).
REQ-003 SHALL provide parameter BANK_BITS, default 3, bank select width; number of banks NBANKS = 2^BANK_BITS.
REQ-004 SHALL provide parameter WAIT_STATES, default 1, range 0..15; wait cycles inserted before each access.
REQ-005 SHALL provide parameter WP_MASK, default 0, NBANKS bits; bit b set makes bank b write-protected.
REQ-006 SHALL have port clk  in  1  rising-edge clock.
REQ-007 SHALL have port reset  in  1  reset, synchronous, active-high; clock clk.
REQ-008 SHALL have port ce  in  1  access request, held high until ready.
REQ-009 SHALL have port oce  in  1  output enable for reads.
REQ-010 SHALL have port wre  in  1  1 = write, 0 = read; sampled at request capture.
REQ-011 SHALL have port ad  in  AW  in-page address.
REQ-012 SHALL have port data_bus  inout  DW  shared tri-state data bus.
REQ-013 SHALL have port page_we  in  1  page register write strobe.
REQ-014 SHALL have port page_din  in  BANK_BITS+1  [BANK_BITS-1:0] = bank; [BANK_BITS] = lock.
REQ-015 SHALL have port bank  out  BANK_BITS  current page register bank.
REQ-016 SHALL have port ready  out  1  access complete; high only in DONE.
REQ-017 SHALL have port wp_err  out  1  one-cycle pulse on dropped protected write.

Function
REQ-018 Memory SHALL be 2^(AW+BANK_BITS) words of DW bits, addressed by {bank_latched, ad_latched}.
REQ-019 FSM states SHALL be IDLE, WAIT, ACCESS, DONE.
REQ-020 IDLE with ce=1 at edge N: latch ad, wre, data_bus (write data) and bank; next state WAIT with counter = WAIT_STATES, or ACCESS if WAIT_STATES=0.
REQ-021 WAIT: counter decrements each edge; at the edge where counter reaches 1, next state ACCESS; WAIT lasts exactly WAIT_STATES cycles.
REQ-022 ACCESS (one cycle): read loads dout from memory; write stores latched data unless bank is protected; next state DONE.
REQ-023 ready SHALL first be high in the cycle after edge N+WAIT_STATES+1; latency is WAIT_STATES+2 cycles from the first ce-high cycle.
REQ-024 DONE: hold ready=1 and dout while ce=1; on ce=0 go to IDLE; no new request is captured until ce has been low for at least one cycle.
REQ-025 data_bus SHALL be driven with dout only when state=DONE, ce=1, oce=1 and latched wre=0; otherwise high-Z.
REQ-026 ce=0 while in WAIT or ACCESS SHALL abort to IDLE at the next edge; no memory write occurs if ce is low in ACCESS; ready stays 0.
REQ-027 Write to a bank whose WP_MASK bit is set SHALL leave memory unchanged, pulse wp_err for exactly the first DONE cycle, and still assert ready.
REQ-028 page_we=1 with lock=0 SHALL load the page register at that edge in any state; an in-flight access keeps its latched bank.
REQ-029 page_we coincident with request capture: the request SHALL use the old bank.
REQ-030 When the lock bit is 1, further page_we SHALL be ignored until reset; the write that sets lock also loads its bank field.

Reset
REQ-031 On reset: state IDLE, ready=0, wp_err=0, dout=0, bank=0, lock=0, wait counter=0, data_bus high-Z.
REQ-032 Reset mid-access SHALL abandon the access with no memory write; memory contents SHALL NOT be cleared.

Verification
REQ-033 WAIT_STATES=1: write 8'hA5 to bank 0 ad 14'h0010, then read it back -> ready 3 cycles after ce rises; data_bus = 8'hA5 only while ce&oce.
REQ-034 Write 8'h11 to bank 2 and 8'h22 to bank 5 at ad 14'h0000 -> reads return 8'h11 and 8'h22 respectively.
REQ-035 WP_MASK=8'h01: write 8'h77 to bank 0 ad 0 -> wp_err pulses once, ready asserted, read-back returns previous value.
REQ-036 page_din=4'b1011 then page_din=4'b0001 -> bank stays 3 until reset, after which bank=0.
REQ-037 Drop ce during WAIT of a write -> no ready, memory unchanged; reset asserted during ACCESS -> state IDLE, ready=0.
REQ-038 WAIT_STATES=0 and 4 sweep: measure ready latency -> 2 and 6 cycles respectively.
